alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (min 8).
REQ-002 SHALL have port clk  input  1  single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  4  operation select.
REQ-007 SHALL have port src_a  input  WIDTH  operand A.
REQ-008 SHALL have port src_b  input  WIDTH  operand B.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  high when result == 0.
REQ-013 SHALL have port div_by_zero  output  1  qualifies out_valid, high for DIV/DIVU with src_b == 0.

Function
REQ-014 SHALL encode op: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0101 SLTU, 0110 SUB, 0111 SLT (signed), 1000 MULT, 1001 MULTU, 1010 DIV, 1011 DIVU, 1100 MFHI, 1101 MFLO; other codes give result 0, zero 1, latency 1.
REQ-015 SHALL accept a request on a clock edge where in_valid && in_ready; operands and op are captured on that edge.
REQ-016 SHALL drive in_ready high only in state IDLE with no unconsumed result.
REQ-017 SHALL use states IDLE, MUL, DIV, DONE: IDLE->DONE for single-cycle ops, MFHI/MFLO and divide-by-zero; IDLE->MUL for MULT/MULTU; IDLE->DIV for DIV/DIVU; MUL/DIV->DONE after WIDTH iterations; DONE->IDLE on out_ready.
REQ-018 SHALL assert out_valid in the cycle after accept for single-cycle ops, and exactly WIDTH+1 cycles after the accept cycle for MUL/DIV.
REQ-019 SHALL hold result, zero, div_by_zero and out_valid stable while out_valid && !out_ready.
REQ-020 SHALL compute ADD/SUB modulo 2^WIDTH with no overflow detection; SLT/SLTU give 1 or 0 zero-extended.
REQ-021 SHALL compute MULT/MULTU as the 2*WIDTH-bit product via iterative shift-add on operand magnitudes with final sign fix, writing HI = upper half, LO = lower half; result = LO.
REQ-022 SHALL compute DIV/DIVU via restoring division: LO = quotient truncated toward zero, HI = remainder with sign of dividend; result = LO.
REQ-023 SHALL return LO = most-negative value, HI = 0 for signed DIV of most-negative by -1.
REQ-024 SHALL, on divide by zero, skip iteration, leave HI/LO unchanged, output result 0 and div_by_zero 1.
REQ-025 SHALL update HI/LO only on completion of MULT/MULTU/DIV/DIVU; MFHI/MFLO return the value before any pending update.
REQ-026 SHALL ignore in_valid while not in_ready; no request is queued.

Reset
REQ-027 SHALL, while rst_n low, force state IDLE, iteration counter 0, HI = LO = 0, result 0, zero 1, out_valid 0, div_by_zero 0, in_ready 0.
REQ-028 SHALL abort any in-flight MUL/DIV on reset with no partial HI/LO update; in_ready rises on the first edge after rst_n deasserts.

Structure
REQ-029 SHALL place the op encoding, state enum and default WIDTH in shared package alu_pkg.
REQ-030 SHALL implement the shared shift-add/restoring iteration datapath and counter in one sub-module, muldiv_iter.

Verification (WIDTH = 32)
REQ-031 SHALL cover ADD 0xFFFFFFFF + 0x00000001 -> result 0, zero 1, out_valid in the cycle after accept.
REQ-032 SHALL cover MULT 0xFFFFFFFE * 0x00000003 -> out_valid 33 cycles after accept, result 0xFFFFFFFA; then MFHI -> 0xFFFFFFFF.
REQ-033 SHALL cover DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD; then MFHI -> 0xFFFFFFFF; and DIV 0x80000000 / 0xFFFFFFFF -> LO 0x80000000, HI 0.
REQ-034 SHALL cover DIVU 5 / 0 -> div_by_zero 1, result 0, latency 1, and a subsequent MFLO returns the prior LO.
REQ-035 SHALL cover out_ready held low 5 cycles after SLT 0xFFFFFFFF, 1 -> result 1 stable, in_ready 0, a concurrent in_valid ignored.
REQ-036 SHALL cover rst_n pulsed low 10 cycles into a DIVU -> out_valid 0, HI = LO = 0, in_ready 1 one edge after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU / multiply-divide block:
// op encoding, control states and default datapath width.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [3:0] {
        OP_AND   = 4'b0000,
        OP_OR    = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_XOR   = 4'b0011,
        OP_NOR   = 4'b0100,
        OP_SLTU  = 4'b0101,
        OP_SUB   = 4'b0110,
        OP_SLT   = 4'b0111,
        OP_MULT  = 4'b1000,
        OP_MULTU = 4'b1001,
        OP_DIV   = 4'b1010,
        OP_DIVU  = 4'b1011,
        OP_MFHI  = 4'b1100,
        OP_MFLO  = 4'b1101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_MUL  = 2'b01,
        S_DIV  = 2'b10,
        S_DONE = 2'b11
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned iterative datapath shared by shift-add multiply and
// restoring divide; one bit per step, next-step values exposed.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             last,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rsh;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH-1:0] lo_s;

    always_comb begin
        sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        rsh  = {acc_q, lo_q[WIDTH-1]};
        ge   = rsh >= {1'b0, b_q};
        // only taken when ge, so the difference always fits WIDTH bits
        diff = rsh[WIDTH-1:0] - b_q;
        if (is_div) begin
            acc_s = ge ? diff : rsh[WIDTH-1:0];
            lo_s  = {lo_q[WIDTH-2:0], ge};
        end else begin
            acc_s = sum[WIDTH:1];
            lo_s  = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        if (start) begin
            acc_d = '0;
            lo_d  = a_in;
            b_d   = b_in;
            cnt_d = '0;
        end else if (step) begin
            acc_d = acc_s;
            lo_d  = lo_s;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
        end
    end

    assign last   = (cnt_q == LAST_CNT);
    assign hi_nxt = acc_s;
    assign lo_nxt = lo_s;

endmodule

// File: rtl/alu_muldiv.sv
// Single-cycle ALU plus iterative MULT/DIV with HI/LO registers
// behind a valid/ready request and result handshake.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero
);

    state_e state_q, state_d;

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;
    logic             dbz_q, dbz_d;
    logic             in_ready_q, in_ready_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    op_e              op_i;
    logic             accept;
    logic             sgn;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] alu_res;

    logic             it_start, it_step, it_last;
    logic [WIDTH-1:0] it_hi, it_lo;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo, rem;

    assign op_i   = op_e'(op);
    assign accept = in_valid && in_ready_q;

    always_comb begin
        sgn   = (op_i == OP_MULT) || (op_i == OP_DIV);
        a_neg = sgn && src_a[WIDTH-1];
        b_neg = sgn && src_b[WIDTH-1];
        a_mag = a_neg ? ('0 - src_a) : src_a;
        b_mag = b_neg ? ('0 - src_b) : src_b;
    end

    always_comb begin
        case (op_i)
            OP_AND:  alu_res = src_a & src_b;
            OP_OR:   alu_res = src_a | src_b;
            OP_ADD:  alu_res = src_a + src_b;
            OP_XOR:  alu_res = src_a ^ src_b;
            OP_NOR:  alu_res = ~(src_a | src_b);
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_SUB:  alu_res = src_a - src_b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                                $signed(src_a) < $signed(src_b)};
            OP_MFHI: alu_res = hi_q;
            OP_MFLO: alu_res = lo_q;
            default: alu_res = '0;
        endcase
    end

    // sign fix-up applied to the final step's values
    always_comb begin
        prod     = {it_hi, it_lo};
        prod_fix = negq_q ? ('0 - prod) : prod;
        quo      = negq_q ? ('0 - it_lo) : it_lo;
        rem      = negr_q ? ('0 - it_hi) : it_hi;
    end

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        dbz_d       = dbz_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        it_start    = 1'b0;
        it_step     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    dbz_d = 1'b0;
                    case (op_i)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_MUL;
                            it_start = 1'b1;
                            negq_d   = a_neg ^ b_neg;
                            negr_d   = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == '0) begin
                                state_d  = S_DONE;
                                result_d = '0;
                                dbz_d    = 1'b1;
                            end else begin
                                state_d  = S_DIV;
                                it_start = 1'b1;
                                negq_d   = a_neg ^ b_neg;
                                negr_d   = a_neg;
                            end
                        end
                        default: begin
                            state_d  = S_DONE;
                            result_d = alu_res;
                        end
                    endcase
                end
            end
            S_MUL: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d  = S_DONE;
                    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d     = prod_fix[WIDTH-1:0];
                    result_d = prod_fix[WIDTH-1:0];
                end
            end
            S_DIV: begin
                it_step = 1'b1;
                if (it_last) begin
                    state_d  = S_DONE;
                    hi_d     = rem;
                    lo_d     = quo;
                    result_d = quo;
                end
            end
            default: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
        endcase
        zero_d      = (result_d == '0);
        out_valid_d = (state_d == S_DONE);
        in_ready_d  = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
        end
    end

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (it_start),
        .step   (it_step),
        .is_div (state_q == S_DIV),
        .a_in   (a_mag),
        .b_in   (b_mag),
        .last   (it_last),
        .hi_nxt (it_hi),
        .lo_nxt (it_lo)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed-vector bench for alu_muldiv at WIDTH = 32.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [3:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        int           lat;
        logic         dz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] src_a = '0;
    logic [W-1:0] src_b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         zero;
    logic         div_by_zero;

    int nvec = 0;
    int nmiss = 0;
    int lat;
    vec_t tbl[$];

    always #5 clk = ~clk;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .src_a       (src_a),
        .src_b       (src_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmiss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, output int l);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("in_ready before issue", in_ready, 1);
        in_valid = 1'b1;
        op = o;
        src_a = a;
        src_b = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        l = 0;
        while (!out_valid && l < 100) begin
            @(posedge clk);
            #1;
            l++;
        end
    endtask

    task automatic consume();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic add(input logic [3:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] r,
                       input int l, input logic dz);
        vec_t v;
        v.o = o; v.a = a; v.b = b; v.r = r; v.lat = l; v.dz = dz;
        tbl.push_back(v);
    endtask

    initial begin
        add(OP_ADD,   32'hFFFFFFFF, 32'h1,        32'h0,        0,  0);
        add(OP_MULT,  32'hFFFFFFFE, 32'h3,        32'hFFFFFFFA, 32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 0,  0);
        add(OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFF, 0,  0);
        add(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'h0,        0,  0);
        add(OP_DIVU,  32'h5,        32'h0,        32'h0,        0,  1);
        add(OP_MFLO,  32'h0,        32'h0,        32'h80000000, 0,  0);
        add(OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0,  0);
        add(OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 0,  0);
        add(OP_XOR,   32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 0,  0);
        add(OP_NOR,   32'h0,        32'h0,        32'hFFFFFFFF, 0,  0);
        add(OP_SLTU,  32'hFFFFFFFF, 32'h1,        32'h0,        0,  0);
        add(OP_SUB,   32'h0,        32'h1,        32'hFFFFFFFF, 0,  0);
        add(OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        0,  0);
        add(OP_DIVU,  32'd100,      32'd7,        32'd14,       32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'd2,        0,  0);
        add(OP_DIV,   32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'd1,        0,  0);
        add(OP_MULT,  32'h80000000, 32'h80000000, 32'h0,        32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'h40000000, 0,  0);
        add(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1,        32, 0);
        add(OP_MFHI,  32'h0,        32'h0,        32'hFFFFFFFE, 0,  0);
        add(4'b1110,  32'h1234,     32'h5678,     32'h0,        0,  0);

        repeat (3) @(negedge clk);
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst result", result, 0);
        chk("rst zero", zero, 1);
        chk("rst dbz", div_by_zero, 0);
        rst_n = 1'b1;
        #1;
        chk("in_ready before first edge", in_ready, 0);
        @(posedge clk);
        #1;
        chk("in_ready after release", in_ready, 1);

        foreach (tbl[i]) begin
            issue(tbl[i].o, tbl[i].a, tbl[i].b, lat);
            chk($sformatf("v%0d result", i), result, tbl[i].r);
            chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d zero", i), zero, tbl[i].r == '0);
            chk($sformatf("v%0d dbz", i), div_by_zero, tbl[i].dz);
            consume();
        end

        issue(OP_SLT, 32'hFFFFFFFF, 32'h1, lat);
        chk("slt latency", lat, 0);
        @(negedge clk);
        in_valid = 1'b1;
        op = OP_ADD;
        src_a = 32'd5;
        src_b = 32'd6;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("hold result", result, 1);
            chk("hold out_valid", out_valid, 1);
            chk("hold in_ready", in_ready, 0);
            chk("hold zero", zero, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hold in_ready after take", in_ready, 1);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("ignored request", out_valid, 0);
        end

        @(negedge clk);
        chk("in_ready before divu", in_ready, 1);
        in_valid = 1'b1;
        op = OP_DIVU;
        src_a = 32'd100;
        src_b = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort out_valid", out_valid, 0);
        chk("abort in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("abort in_ready release", in_ready, 1);
        chk("abort out_valid release", out_valid, 0);
        issue(OP_MFHI, 32'h0, 32'h0, lat);
        chk("abort hi", result, 0);
        consume();
        issue(OP_MFLO, 32'h0, 32'h0, lat);
        chk("abort lo", result, 0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
